// File: rtl/sim_run_ctrl.sv
// rtl/sim_run_ctrl.sv - run controller: core reset sequencing, cycle/instret counting, run termination
module sim_run_ctrl #(
    parameter int RESET_CYCLES    = 5,
    parameter int MAX_CYCLES      = 50,
    parameter int WATCHDOG_CYCLES = 1000,
    parameter int COMMIT_WIDTH    = 2,
    parameter int CNT_W           = 32,
    parameter int XLEN            = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic [COMMIT_WIDTH-1:0] commit_halt,
    input  logic                    tohost_we,
    input  logic [XLEN-1:0]         tohost_data,
    output logic                    core_rst,
    output logic                    running,
    output logic                    done,
    output logic [2:0]              status,
    output logic [XLEN-1:0]         exit_code,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        instret_count
);

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int PC_W  = $clog2(COMMIT_WIDTH + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WATCHDOG_CYCLES);
    localparam logic [CNT_W-1:0] CY_LIMIT = CNT_W'(MAX_CYCLES);
    localparam logic             WD_EN    = (WATCHDOG_CYCLES != 0);
    localparam logic             CY_EN    = (MAX_CYCLES != 0);

    localparam logic [2:0] ST_NONE     = 3'd0;
    localparam logic [2:0] ST_PASS     = 3'd1;
    localparam logic [2:0] ST_FAIL     = 3'd2;
    localparam logic [2:0] ST_TIMEOUT  = 3'd3;
    localparam logic [2:0] ST_WATCHDOG = 3'd4;
    localparam logic [2:0] ST_HALT     = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [RST_W-1:0]  rst_cnt_q;
    logic [CNT_W-1:0]  wd_cnt_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  instret_q;
    logic [2:0]        status_q;
    logic [XLEN-1:0]   exit_q;
    logic              core_rst_q;
    logic              running_q;
    logic              done_q;

    logic [PC_W-1:0]   commits;
    logic [CNT_W:0]    cycle_sum;
    logic [CNT_W:0]    instret_sum;
    logic [CNT_W:0]    wd_sum;
    logic [CNT_W-1:0]  cycle_d;
    logic [CNT_W-1:0]  instret_d;
    logic [CNT_W-1:0]  wd_cnt_d;
    logic              term;
    logic [2:0]        status_d;
    logic [XLEN-1:0]   exit_d;

    // Next-cycle RUN counters (saturating) and prioritised termination decision
    always_comb begin
        commits = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commits = commits + PC_W'(commit_valid[i]);
        end

        cycle_sum   = {1'b0, cycle_q} + {{CNT_W{1'b0}}, 1'b1};
        instret_sum = {1'b0, instret_q} + (CNT_W+1)'(commits);
        wd_sum      = {1'b0, wd_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

        cycle_d   = cycle_sum[CNT_W]   ? {CNT_W{1'b1}} : cycle_sum[CNT_W-1:0];
        instret_d = instret_sum[CNT_W] ? {CNT_W{1'b1}} : instret_sum[CNT_W-1:0];
        if (|commit_valid) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_sum[CNT_W] ? {CNT_W{1'b1}} : wd_sum[CNT_W-1:0];
        end

        term     = 1'b1;
        status_d = ST_NONE;
        exit_d   = '0;
        if (tohost_we) begin
            if (tohost_data == XLEN'(1)) begin
                status_d = ST_PASS;
            end else begin
                status_d = ST_FAIL;
                exit_d   = tohost_data >> 1;
            end
        end else if (|(commit_valid & commit_halt)) begin
            status_d = ST_HALT;
        end else if (WD_EN && (wd_cnt_d == WD_LIMIT)) begin
            status_d = ST_WATCHDOG;
        end else if (CY_EN && (cycle_d == CY_LIMIT)) begin
            status_d = ST_TIMEOUT;
        end else begin
            term = 1'b0;
        end
    end

    // Run FSM with registered outputs; leaving IDLE/DONE on start wipes the previous run's results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rst_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            cycle_q    <= '0;
            instret_q  <= '0;
            status_q   <= ST_NONE;
            exit_q     <= '0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    core_rst_q <= 1'b1;
                    running_q  <= 1'b0;
                    if (start) begin
                        state_q   <= S_RESET;
                        done_q    <= 1'b0;
                        rst_cnt_q <= '0;
                        wd_cnt_q  <= '0;
                        cycle_q   <= '0;
                        instret_q <= '0;
                        status_q  <= ST_NONE;
                        exit_q    <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q    <= S_RUN;
                        core_rst_q <= 1'b0;
                        running_q  <= 1'b1;
                        wd_cnt_q   <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_q   <= cycle_d;
                    instret_q <= instret_d;
                    wd_cnt_q  <= wd_cnt_d;
                    if (term) begin
                        state_q    <= S_DONE;
                        core_rst_q <= 1'b1;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                        status_q   <= status_d;
                        exit_q     <= exit_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign core_rst      = core_rst_q;
    assign running       = running_q;
    assign done          = done_q;
    assign status        = status_q;
    assign exit_code     = exit_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb/tb_sim_run_ctrl.sv - bench for sim_run_ctrl: two parameterisations against a behavioural model
module tb_sim_run_ctrl;

    localparam int RC = 5;

    localparam int P_IDLE  = 0;
    localparam int P_RESET = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;

    localparam longint A_SAT = 64'hFFFF_FFFF;
    localparam longint B_SAT = 64'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cv;
    logic [1:0]  ch;
    logic        we;
    logic [31:0] d;

    logic        a_core_rst, a_running, a_done;
    logic [2:0]  a_status;
    logic [31:0] a_exit, a_cyc, a_ins;
    logic        b_core_rst, b_running, b_done;
    logic [2:0]  b_status;
    logic [31:0] b_exit;
    logic [3:0]  b_cyc, b_ins;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    sim_run_ctrl #(.RESET_CYCLES(RC), .MAX_CYCLES(50), .WATCHDOG_CYCLES(0),
                   .COMMIT_WIDTH(2), .CNT_W(32), .XLEN(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .commit_valid(cv), .commit_halt(ch),
        .tohost_we(we), .tohost_data(d), .core_rst(a_core_rst), .running(a_running),
        .done(a_done), .status(a_status), .exit_code(a_exit), .cycle_count(a_cyc),
        .instret_count(a_ins));

    sim_run_ctrl #(.RESET_CYCLES(RC), .MAX_CYCLES(0), .WATCHDOG_CYCLES(8),
                   .COMMIT_WIDTH(2), .CNT_W(4), .XLEN(32)) dut_b (
        .clk(clk), .rst(rst), .start(start), .commit_valid(cv), .commit_halt(ch),
        .tohost_we(we), .tohost_data(d), .core_rst(b_core_rst), .running(b_running),
        .done(b_done), .status(b_status), .exit_code(b_exit), .cycle_count(b_cyc),
        .instret_count(b_ins));

    typedef struct {
        int     ph;
        int     rc;
        longint cyc;
        longint ins;
        longint wd;
        int     st;
        longint ex;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_clear();
        mdl_t n;
        n.ph = P_IDLE; n.rc = 0; n.cyc = 0; n.ins = 0; n.wd = 0; n.st = 0; n.ex = 0;
        return n;
    endfunction

    function automatic longint sat(input longint v, input longint cmax);
        return (v > cmax) ? cmax : v;
    endfunction

    // One clock of the run controller described in terms of phases and arithmetic
    function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit s,
                                      input bit [1:0] v, input bit [1:0] h, input bit w,
                                      input bit [31:0] dd, input longint maxc,
                                      input longint wdc, input longint cmax);
        mdl_t n = m;
        int k;
        if (r) return mdl_clear();
        case (m.ph)
            P_IDLE, P_DONE: begin
                if (s) begin
                    n = mdl_clear();
                    n.ph = P_RESET;
                    n.rc = RC;
                end
            end
            P_RESET: begin
                n.rc = m.rc - 1;
                if (n.rc == 0) n.ph = P_RUN;
            end
            default: begin
                k = int'(v[0]) + int'(v[1]);
                n.cyc = sat(m.cyc + 1, cmax);
                n.ins = sat(m.ins + k, cmax);
                n.wd  = (k != 0) ? 0 : sat(m.wd + 1, cmax);
                if (w) begin
                    n.ph = P_DONE;
                    n.st = (dd == 32'd1) ? 1 : 2;
                    n.ex = (dd == 32'd1) ? 0 : longint'(dd >> 1);
                end else if ((v & h) != 2'b00) begin
                    n.ph = P_DONE; n.st = 5;
                end else if (wdc != 0 && n.wd == wdc) begin
                    n.ph = P_DONE; n.st = 4;
                end else if (maxc != 0 && n.cyc == maxc) begin
                    n.ph = P_DONE; n.st = 3;
                end
            end
        endcase
        return n;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against their models, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("a.core_rst", 64'(a_core_rst), 64'(ma.ph != P_RUN));
            check("a.running",  64'(a_running),  64'(ma.ph == P_RUN));
            check("a.done",     64'(a_done),     64'(ma.ph == P_DONE));
            check("a.status",   64'(a_status),   64'(ma.st));
            check("a.exit",     64'(a_exit),     64'(ma.ex));
            check("a.cycles",   64'(a_cyc),      64'(ma.cyc));
            check("a.instret",  64'(a_ins),      64'(ma.ins));
            check("b.core_rst", 64'(b_core_rst), 64'(mb.ph != P_RUN));
            check("b.running",  64'(b_running),  64'(mb.ph == P_RUN));
            check("b.done",     64'(b_done),     64'(mb.ph == P_DONE));
            check("b.status",   64'(b_status),   64'(mb.st));
            check("b.exit",     64'(b_exit),     64'(mb.ex));
            check("b.cycles",   64'(b_cyc),      64'(mb.cyc));
            check("b.instret",  64'(b_ins),      64'(mb.ins));
        end
    end

    task automatic cyc(input bit r, input bit s, input bit [1:0] v, input bit [1:0] h,
                       input bit w, input bit [31:0] dd);
        rst = r; start = s; cv = v; ch = h; we = w; d = dd;
        @(posedge clk);
        ma = mdl_step(ma, r, s, v, h, w, dd, 50, 0, A_SAT);
        mb = mdl_step(mb, r, s, v, h, w, dd, 0, 8, B_SAT);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 2'b00, 2'b00, 0, 0);
    endtask

    // Reset both DUTs, pulse start, and leave both observing RUN cycle 1
    task automatic start_run();
        cyc(1, 0, 2'b00, 2'b00, 0, 0);
        cyc(0, 1, 2'b00, 2'b00, 0, 0);
        idle(RC);
    endtask

    initial begin
        int hi, rn, mode;
        bit [1:0] v, h;
        bit w, s, r;
        bit [31:0] dd;

        rst = 1'b1; start = 1'b0; cv = '0; ch = '0; we = 1'b0; d = '0;
        ma = mdl_clear();
        mb = mdl_clear();
        cyc(1, 0, 2'b00, 2'b00, 0, 0);
        cyc(1, 0, 2'b00, 2'b00, 0, 0);
        cmp_en = 1'b1;

        check("rst.core_rst", 64'(a_core_rst), 64'd1);
        check("rst.status",   64'(a_status),   64'd0);
        check("rst.cycles",   64'(a_cyc),      64'd0);

        // Cycle limit on dut_a: 5 reset cycles, 50 run cycles, then TIMEOUT
        cyc(0, 1, 2'b00, 2'b00, 0, 0);
        hi = 0; rn = 0;
        for (int i = 0; i < 55; i++) begin
            hi += int'(a_core_rst);
            rn += int'(a_running);
            cyc(0, 0, 2'b00, 2'b00, 0, 0);
        end
        check("lim.reset_len", 64'(hi), 64'd5);
        check("lim.run_len",   64'(rn), 64'd50);
        check("lim.done",      64'(a_done), 64'd1);
        check("lim.status",    64'(a_status), 64'd3);
        check("lim.cycles",    64'(a_cyc), 64'd50);
        check("lim.instret",   64'(a_ins), 64'd0);
        check("lim.core_rst",  64'(a_core_rst), 64'd1);

        // Restart from DONE clears results; second run ends identically
        cyc(0, 1, 2'b00, 2'b00, 0, 0);
        check("rs.cycles", 64'(a_cyc), 64'd0);
        check("rs.status", 64'(a_status), 64'd0);
        check("rs.done",   64'(a_done), 64'd0);
        idle(RC + 50);
        check("rs.status2", 64'(a_status), 64'd3);
        check("rs.cycles2", 64'(a_cyc), 64'd50);

        // Multi-lane instret then PASS
        start_run();
        cyc(0, 0, 2'b11, 2'b00, 0, 0);
        cyc(0, 0, 2'b01, 2'b00, 0, 0);
        cyc(0, 0, 2'b10, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 2'b00, 0, 0);
        cyc(0, 0, 2'b11, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 2'b00, 1, 32'd1);
        check("ml.status",  64'(a_status), 64'd1);
        check("ml.instret", 64'(a_ins), 64'd6);
        check("ml.cycles",  64'(a_cyc), 64'd6);
        check("ml.exit",    64'(a_exit), 64'd0);
        check("ml.b_status", 64'(b_status), 64'd1);

        // tohost FAIL beats a halt commit in the same cycle; the commit is counted
        start_run();
        cyc(0, 0, 2'b01, 2'b01, 1, 32'h0B);
        check("pr.status",  64'(a_status), 64'd2);
        check("pr.exit",    64'(a_exit), 64'd5);
        check("pr.instret", 64'(a_ins), 64'd1);

        // Watchdog on dut_b; halt flags without valid must not terminate
        start_run();
        idle(2);
        cyc(0, 0, 2'b01, 2'b00, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 2'b00, 2'b11, 0, 0);
        check("wd.not_yet", 64'(b_done), 64'd0);
        cyc(0, 0, 2'b00, 2'b10, 0, 0);
        check("wd.done",   64'(b_done), 64'd1);
        check("wd.status", 64'(b_status), 64'd4);
        check("wd.cycles", 64'(b_cyc), 64'd11);
        check("wd.a_run",  64'(a_running), 64'd1);

        // Start ignored in RUN, then reset mid-run
        start_run();
        for (int i = 1; i < 20; i++) cyc(0, (i == 10), 2'($urandom_range(1, 3)), 2'b00, 0, 0);
        check("mr.cycles", 64'(a_cyc), 64'd19);
        cyc(1, 0, 2'b11, 2'b00, 0, 0);
        check("mr.core_rst", 64'(a_core_rst), 64'd1);
        check("mr.running",  64'(a_running), 64'd0);
        check("mr.cycles0",  64'(a_cyc), 64'd0);
        check("mr.instret0", 64'(a_ins), 64'd0);

        // Randomised runs checked by the per-cycle compare
        for (int run = 0; run < 25; run++) begin
            start_run();
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 100; i++) begin
                v  = (mode == 0 && $urandom_range(0, 3) != 0) ? 2'b00 : 2'($urandom);
                h  = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
                w  = ($urandom_range(0, 39) == 0);
                dd = ($urandom_range(0, 2) == 0) ? 32'd1 : 32'($urandom);
                s  = ($urandom_range(0, 24) == 0);
                r  = ($urandom_range(0, 199) == 0);
                cyc(r, s, v, h, w, dd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
